// File: rtl/alu_and_dec_div.sv
// Start/done coprocessor beside the main ALU: AND and decrement finish on the capture edge,
// unsigned divide/modulo runs a restoring divider, one quotient bit per clock.
module alu_and_dec_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rest,
  output logic [4:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MOD = 2'b11;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       op_q;
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, and_res, dec_res;
  logic             last_iter, dec_carry, dec_ovf;

  // Flag vector {overflow, parity(even), sign, carry, zero} from the new result
  function automatic logic [4:0] make_flags(input logic [WIDTH-1:0] res,
                                            input logic c, input logic v);
    make_flags = {v, ~^res, res[WIDTH-1], c, (res == '0)};
  endfunction

  always_comb begin
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_sh - {1'b0, dsr_q};
    rem_nxt   = trial[WIDTH-1:0];
    quo_nxt   = {quo_q[WIDTH-2:0], 1'b1};
    // Borrow means the divisor did not fit: restore the shifted remainder
    if (trial[WIDTH]) begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
    end
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    and_res   = operand1 & operand2;
    dec_res   = operand1 - WIDTH'(1);
    dec_carry = (operand1 == '0);
    dec_ovf   = (operand1 == {1'b1, {(WIDTH-1){1'b0}}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      rest   <= '0;
      flags  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      op_q   <= OP_AND;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_iter) begin
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= (op_q == OP_DIV) ? quo_nxt : rem_nxt;
          rest   <= rem_nxt;
          flags  <= make_flags((op_q == OP_DIV) ? quo_nxt : rem_nxt, 1'b0, (dsr_q == '0));
        end
      end else if (start) begin
        case (op)
          OP_AND: begin
            result <= and_res;
            rest   <= '0;
            flags  <= make_flags(and_res, 1'b0, 1'b0);
            done   <= 1'b1;
          end
          OP_DEC: begin
            result <= dec_res;
            rest   <= '0;
            flags  <= make_flags(dec_res, dec_carry, dec_ovf);
            done   <= 1'b1;
          end
          OP_DIV, OP_MOD: begin
            op_q  <= op;
            rem_q <= '0;
            quo_q <= operand1;
            dsr_q <= operand2;
            cnt_q <= '0;
            busy  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_and_dec_div.sv
// Scoreboard bench for alu_and_dec_div: expectations are queued at issue and
// compared (value and latency) when done pulses.
module tb_alu_and_dec_div;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] operand1 = '0, operand2 = '0;
  logic [W-1:0] result, rest;
  logic [4:0]   flags;
  logic         busy, done;

  alu_and_dec_div #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand1(operand1), .operand2(operand2),
    .result(result), .rest(rest), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rst_v;
    logic [4:0]   flg;
    int           lat;
    int           issue;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_flags(input logic [W-1:0] r, input logic c, input logic v);
    int ones = 0;
    for (int i = 0; i < W; i++) ones += int'(r[i]);
    return {v, ((ones % 2) == 0), r[W-1], c, (r == 0)};
  endfunction

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] q, m;
    e.issue = 0;
    case (o)
      2'b00: begin e.res = a & b; e.rst_v = 0; e.flg = model_flags(a & b, 0, 0); e.lat = 1; end
      2'b01: begin
        e.res = a - 8'd1; e.rst_v = 0;
        e.flg = model_flags(a - 8'd1, a == 8'h00, a == 8'h80); e.lat = 1;
      end
      default: begin
        q = (b == 0) ? 8'hFF : a / b;
        m = (b == 0) ? a : a % b;
        e.res = (o == 2'b10) ? q : m; e.rst_v = m;
        e.flg = model_flags(e.res, 0, b == 0); e.lat = W + 1;
      end
    endcase
    return e;
  endfunction

  // Completion monitor: every done pops one expectation
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("rest", rest, e.rst_v);
        check("flags", flags, e.flg);
        check("latency", cyc - e.issue, e.lat);
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clk);
    op = o; operand1 = a; operand2 = b; start = 1'b1;
    e = model(o, a, b);
    e.issue = cyc;
    exp_q.push_back(e);
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Expected values from the worked examples: {result, rest, flags}
  task automatic check_last(input string tag, input logic [W-1:0] r, input logic [W-1:0] m, input logic [4:0] f);
    check({tag, "_res"}, result, r);
    check({tag, "_rest"}, rest, m);
    check({tag, "_flags"}, flags, f);
  endtask

  initial begin
    #1;
    check("reset_result", result, 0);
    check("reset_flags", flags, 0);
    check("reset_busy_done", {busy, done}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(2'b00, 8'hF0, 8'h3C); release_start();
    check("and_busy", busy, 0);
    wait_idle(); check_last("and", 8'h30, 8'h00, 5'h08);

    issue(2'b01, 8'h00, 8'h12); release_start(); wait_idle(); check_last("dec0", 8'hFF, 8'h00, 5'h0E);
    issue(2'b01, 8'h80, 8'h00); release_start(); wait_idle(); check_last("dec80", 8'h7F, 8'h00, 5'h10);
    issue(2'b01, 8'h01, 8'h00); release_start(); wait_idle(); check_last("dec1", 8'h00, 8'h00, 5'h09);

    issue(2'b10, 8'd200, 8'd7); release_start();
    check("div_busy", busy, 1);
    wait_idle(); check_last("div", 8'h1C, 8'h04, 5'h00);
    issue(2'b11, 8'd200, 8'd7); release_start(); wait_idle(); check_last("mod", 8'h04, 8'h04, 5'h00);
    issue(2'b10, 8'h55, 8'h00); release_start(); wait_idle(); check_last("div0", 8'hFF, 8'h55, 5'h1C);

    // Back-to-back ANDs: second start lands in the cycle done is high
    issue(2'b00, 8'hAA, 8'hFF);
    issue(2'b00, 8'h0F, 8'h3C);
    release_start(); wait_idle();

    // Start during busy is ignored (start sampled on edge 3 after capture)
    issue(2'b10, 8'd250, 8'd9);
    release_start();
    @(negedge clk);
    op = 2'b00; operand1 = 8'h11; operand2 = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignored", busy, 1);
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset in the middle of a divide
    issue(2'b10, 8'd200, 8'd7); release_start();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_result", result, 0);
    check("rst_rest", rest, 0);
    check("rst_flags", flags, 0);
    check("rst_busy_done", {busy, done}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    issue(2'b00, 8'hF0, 8'h3C); release_start(); wait_idle(); check_last("and_after_rst", 8'h30, 8'h00, 5'h08);

    for (int i = 0; i < 12; i++) begin
      issue(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 20)));
      release_start(); wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_and_dec_div.md
Name: alu_and_dec_div

Overview:
- Small sequential arithmetic/logic unit for the 8-bit datapath.
- Performs bitwise AND, decrement-by-one, unsigned divide and unsigned modulo.
- All results and status flags are registered; the divider is iterative (restoring, one bit per cycle).
- Sits beside the main ALU as a start/done coprocessor.

Parameters:
- WIDTH, 8: operand/result width; divider iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled on a rising edge when not busy
- op  in  2  operation select: 00 AND, 01 DEC, 10 DIV (quotient), 11 MOD (remainder)
- operand1  in  WIDTH  A / dividend
- operand2  in  WIDTH  B / divisor; ignored for DEC
- result  out  WIDTH  registered result
- rest  out  WIDTH  registered remainder (DIV/MOD); 0 for AND/DEC
- flags  out  5  [0] zero, [1] carry/borrow, [2] sign, [3] parity, [4] overflow/div-by-zero
- busy  out  1  divider iterating
- done  out  1  one-cycle pulse; result/rest/flags valid from this point

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: result=0, rest=0, flags=0, busy=0, done=0, divider state cleared. Reset mid-operation aborts it and no done is issued.
- Start capture:
  - op, operand1 and operand2 are captured on the edge that samples start=1 with busy=0.
  - start while busy=1 is ignored, with no queueing.
  - Start with busy=0 is also accepted in the same cycle done is high.
- AND:
  - result = operand1 & operand2; rest=0.
  - done=1 after edge 1 (the capture edge); busy stays 0.
- DEC:
  - result = operand1 - 1, modulo 2^WIDTH; rest=0; done after the capture edge; busy stays 0.
  - carry=1 only when operand1==0 (result 0xFF).
  - overflow=1 only when operand1==0x80 (result 0x7F).
- DIV/MOD, restoring unsigned division:
  - Capture edge loads remainder=0, quotient=dividend; busy=1.
  - Each of the next WIDTH edges does one iteration: shift left, trial-subtract divisor, set quotient bit if no borrow.
  - busy goes 0 and done goes 1 on edge WIDTH+1 after capture (edge 9 for WIDTH=8).
  - Outputs: DIV gives result=quotient; MOD gives result=remainder; rest=remainder for both.
  - carry=0.
  - overflow=1 when the divisor is 0. The algorithm then naturally yields quotient=all-ones and remainder=dividend, with the same latency.
- Flags are computed from the new result value, not the previous one:
  - zero = (result==0).
  - sign = result[WIDTH-1].
  - parity = 1 when result has an even number of ones (XNOR-reduce).
  - AND: carry=0, overflow=0.
- Holding: result/rest/flags hold their values until the next completed operation. done is high for exactly one cycle.
- No combinational path from inputs to outputs.

Test Plan:
- AND, op=00, 0xF0 & 0x3C -> one cycle later: result=0x30, rest=0, flags: Z0 C0 S0 P1 V0; done pulses once; busy never high.
- DEC, op=01:
  - 0x00 -> result=0xFF, C1 S1 P1 Z0 V0.
  - 0x80 -> result=0x7F, V1 S0 P0.
  - 0x01 -> result=0x00, Z1 P1.
- DIV, op=10, 200/7 -> busy high for edges 1-8, done at edge 9: result=0x1C, rest=0x04, P0 V0. The same operands with op=11 give result=0x04.
- Divide by zero, op=10, 0x55/0x00 -> edge 9: result=0xFF, rest=0x55, V1 S1 P1.
- Start during busy: start with new operands at edge 3 of a DIV -> ignored; original DIV completes normally with a single done.
- Reset mid-divide: assert rst during edge 4 of a DIV -> outputs immediately 0 (asynchronous); no done afterwards; a new AND after deassertion works normally.
